// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128 key expansion.
// Accepts a 128-bit cipher key and presents round keys 0..10 in order on a
// valid/ready port. One 32-bit schedule word is produced per clock while
// expanding, so each new round key takes four cycles to build.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   begin expansion of key (only honoured when idle)
//   key       in   cipher key, key[127:96] = w0
//   rk        out  current round key {w(4r), w(4r+1), w(4r+2), w(4r+3)}
//   rk_round  out  round index of rk, 0..10
//   rk_valid  out  rk / rk_round valid
//   rk_ready  in   consumer accepts the presented round key
//   busy      out  expansion in progress
//   done      out  one-cycle pulse after round 10 is accepted
module aes_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_EXPAND  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [3:0]  round_q, round_d;
    logic [1:0]  idx_q, idx_d;
    logic        done_q, done_d;

    logic        hs;
    logic [31:0] rot_w3;
    logic [31:0] sub_w;
    logic [31:0] t_w;
    logic [31:0] new_w;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}
    assign rot_w3 = {w3_q[23:0], w3_q[31:24]};

    // SubWord: one substitution box per byte, purely combinational.
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        SBox u_sbox (
            .in_byte  (rot_w3[8*i +: 8]),
            .out_byte (sub_w[8*i +: 8])
        );
    end

    // Only the first word of each round key passes through the nonlinear
    // path; the other three are a plain XOR chain on the previous word.
    always_comb begin
        t_w   = (idx_q == 2'd0) ? (sub_w ^ {rcon_q, 24'h0}) : w3_q;
        new_w = w0_q ^ t_w;
    end

    assign hs = rk_valid & rk_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            rcon_q  <= 8'h01;
            round_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w0_d    = key[127:96];
                    w1_d    = key[95:64];
                    w2_d    = key[63:32];
                    w3_d    = key[31:0];
                    rcon_d  = 8'h01;
                    round_d = 4'd0;
                    idx_d   = 2'd0;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (hs) begin
                    if (round_q == 4'd10) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = S_EXPAND;
                    end
                end
            end
            S_EXPAND: begin
                // Sliding window: after four shifts it holds the next round key.
                w0_d  = w1_q;
                w1_d  = w2_q;
                w2_d  = w3_q;
                w3_d  = new_w;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (idx_q == 2'd3) begin
                    round_d = round_q + 4'd1;
                    state_d = S_PRESENT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        rk_valid = (state_q == S_PRESENT);
        busy     = (state_q != S_IDLE);
    end

    assign rk       = {w0_q, w1_q, w2_q, w3_q};
    assign rk_round = round_q;
    assign done     = done_q;

endmodule

// SBox: AES byte substitution, computed as the multiplicative inverse in
// GF(2^8) (with 0 mapping to 0) followed by the AES affine transform.
//
// Ports:
//   in_byte   in   byte to substitute
//   out_byte  out  substituted byte
module SBox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // a^254 = a^-1 for a != 0, and 0 for a == 0: product of a^2, a^4 .. a^128.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8] ^ a[(i + 7) % 8];
        end
        return b ^ 8'h63;
    endfunction

    always_comb begin
        out_byte = affine(gf_inv(in_byte));
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Testbench for aes_key_schedule: scoreboard of expected round keys built
// from a table-driven reference key expansion, plus known-answer vectors.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    aes_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .rk       (rk),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int c0    = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

    typedef struct {
        logic [127:0] rk;
        logic [3:0]   rnd;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] got_rk [11];

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX_TBL[2047 - 8*int'(x) -: 8];
    endfunction

    // Reference FIPS-197 expansion into 44 words; pushes 11 expected round keys.
    task automatic push_schedule(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        exp_t        e;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])}
                      ^ {RCON_TBL[79 - 8*(i/4 - 1) -: 8], 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) begin
            e.rk  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            e.rnd = 4'(r);
            exp_q.push_back(e);
        end
    endtask

    // Called at a sample point with the DUT idle; returns one cycle after acceptance.
    task automatic start_run(input logic [127:0] k);
        for (int i = 0; i < 11; i++) got_rk[i] = 'x;
        key      = k;
        start    = 1'b1;
        rk_ready = 1'b1;
        push_schedule(k);
        @(posedge clk); #1;
        start = 1'b0;
        key   = ~k;
        c0    = cyc;
        total++;
        if (rk_valid !== 1'b1 || busy !== 1'b1 || rk_round !== 4'd0 || rk !== k) begin
            bad++;
            $display("FAIL start_accept: valid=%b busy=%b round=%0d rk=%h want 1 1 0 %h",
                     rk_valid, busy, rk_round, rk, k);
        end
    endtask

    // Consumes round keys against the scoreboard, with optional stalls,
    // ignored start pulses, or a reset injected mid-expansion.
    task automatic drain(input int stall_a, input int stall_b, input int stall_len,
                         input bit poke, input logic [127:0] poke_key,
                         input int rst_round, input bit chk_lat);
        int           stall_left = 0;
        int           rst_cnt    = -1;
        int           budget     = 300;
        int           r;
        bit           fin        = 1'b0;
        bit           aborted    = 1'b0;
        bit           stalled [11];
        bit           poked   [11];
        logic [127:0] hold_rk;
        logic [3:0]   hold_rnd;
        exp_t         e;
        for (int i = 0; i < 11; i++) begin
            stalled[i] = 1'b0;
            poked[i]   = 1'b0;
        end
        hold_rk  = '0;
        hold_rnd = '0;
        while (!fin && budget > 0) begin
            budget--;
            start    = 1'b0;
            rk_ready = 1'b1;
            if (rst_cnt == 0) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                total++;
                if (rk !== 128'h0 || rk_round !== 4'd0) begin
                    bad++;
                    $display("FAIL reset_mid_data: rk=%h round=%0d want 0 0", rk, rk_round);
                end
                total++;
                if ({rk_valid, busy, done} !== 3'b000) begin
                    bad++;
                    $display("FAIL reset_mid_ctrl: valid/busy/done=%b want 000", {rk_valid, busy, done});
                end
                exp_q.delete();
                aborted = 1'b1;
                break;
            end
            if (rst_cnt > 0) rst_cnt--;
            r = int'(rk_round);
            if (rk_valid === 1'b1 && r <= 10) begin
                if ((r == stall_a || r == stall_b) && !stalled[r]) begin
                    stalled[r] = 1'b1;
                    stall_left = stall_len;
                    hold_rk    = rk;
                    hold_rnd   = rk_round;
                end
                if (poke && (r == 0 || r == 5 || r == 10) && !poked[r]) begin
                    poked[r] = 1'b1;
                    start    = 1'b1;
                    key      = poke_key;
                end
                if (stall_left > 0) begin
                    rk_ready = 1'b0;
                    if (stall_left < stall_len) begin
                        total++;
                        if (rk !== hold_rk || rk_round !== hold_rnd) begin
                            bad++;
                            $display("FAIL stall_hold: rk=%h round=%0d want %h %0d",
                                     rk, rk_round, hold_rk, hold_rnd);
                        end
                    end
                    stall_left--;
                end else begin
                    got_rk[r] = rk;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL round_key: unexpected round %0d rk=%h", r, rk);
                    end else begin
                        e = exp_q.pop_front();
                        if (rk !== e.rk || rk_round !== e.rnd) begin
                            bad++;
                            $display("FAIL round_key: got r%0d %h want r%0d %h",
                                     rk_round, rk, e.rnd, e.rk);
                        end
                    end
                    if (chk_lat && r == 10) begin
                        total++;
                        if (cyc - c0 != 50) begin
                            bad++;
                            $display("FAIL round10_latency: got %0d want 50", cyc - c0);
                        end
                    end
                    if (r == rst_round) rst_cnt = 2;
                    if (r == 10) fin = 1'b1;
                end
            end else if (stall_left > 0) begin
                total++;
                bad++;
                $display("FAIL stall_valid: valid=%b want 1", rk_valid);
                stall_left = 0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!aborted) begin
            total++;
            if (!fin) begin
                bad++;
                $display("FAIL drain_timeout: got no round 10 handshake want one");
            end else begin
                total++;
                if ({done, busy, rk_valid} !== 3'b100) begin
                    bad++;
                    $display("FAIL done_pulse: done/busy/valid=%b want 100", {done, busy, rk_valid});
                end
                if (chk_lat) begin
                    total++;
                    if (cyc - c0 != 51) begin
                        bad++;
                        $display("FAIL done_latency: got %0d want 51", cyc - c0);
                    end
                end
                total++;
                if (exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
                end
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b0;
        key      = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (rk !== 128'h0 || rk_round !== 4'd0) begin
            bad++;
            $display("FAIL reset_data: rk=%h round=%0d want 0 0", rk, rk_round);
        end
        total++;
        if ({rk_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl: valid/busy/done=%b want 000", {rk_valid, busy, done});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: valid=%b busy=%b want 0 0", rk_valid, busy);
        end
    endtask

    task automatic test_fips();
        start_run(FIPS_KEY);
        drain(-1, -1, 0, 1'b0, '0, -1, 1'b1);
        total++;
        if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            bad++;
            $display("FAIL fips_r1: got %h want a0fafe1788542cb123a339392a6c7605", got_rk[1]);
        end
        total++;
        if (got_rk[2] !== 128'hf2c295f27a96b9435935807a7359f67f) begin
            bad++;
            $display("FAIL fips_r2: got %h want f2c295f27a96b9435935807a7359f67f", got_rk[2]);
        end
        total++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            bad++;
            $display("FAIL fips_r10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || rk_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_single: done=%b valid=%b want 0 0", done, rk_valid);
        end
    endtask

    task automatic test_zero_key();
        start_run('0);
        drain(-1, -1, 0, 1'b0, '0, -1, 1'b0);
        total++;
        if (got_rk[1] !== 128'h62636363626363636263636362636363) begin
            bad++;
            $display("FAIL zero_r1: got %h want 62636363626363636263636362636363", got_rk[1]);
        end
        total++;
        if (got_rk[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            bad++;
            $display("FAIL zero_r10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", got_rk[10]);
        end
    endtask

    task automatic test_backpressure();
        start_run(FIPS_KEY);
        drain(3, 9, 7, 1'b0, '0, -1, 1'b0);
        total++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            bad++;
            $display("FAIL bp_r10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
    endtask

    task automatic test_start_ignored();
        start_run(FIPS_KEY);
        drain(-1, -1, 0, 1'b1, ALT_KEY, -1, 1'b0);
        total++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            bad++;
            $display("FAIL ignore_r10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
        @(posedge clk); #1;
        total++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_idle: valid=%b busy=%b want 0 0", rk_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        start_run(FIPS_KEY);
        drain(-1, -1, 0, 1'b0, '0, 5, 1'b0);
        start_run(FIPS_KEY);
        drain(-1, -1, 0, 1'b0, '0, -1, 1'b1);
        total++;
        if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            bad++;
            $display("FAIL rerun_r1: got %h want a0fafe1788542cb123a339392a6c7605", got_rk[1]);
        end
        total++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            bad++;
            $display("FAIL rerun_r10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
    endtask

    task automatic test_back_to_back();
        start_run(FIPS_KEY);
        drain(-1, -1, 0, 1'b0, '0, -1, 1'b0);
        // still on the done cycle here: the next start lands while done=1
        start_run('0);
        drain(-1, -1, 0, 1'b0, '0, -1, 1'b1);
        total++;
        if (got_rk[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            bad++;
            $display("FAIL b2b_r10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", got_rk[10]);
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_zero_key();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key expansion engine. It accepts a 128-bit cipher key and produces the 11 round keys (rounds 0–10) in order. Each round key is presented on a valid/ready output so the downstream round datapath can apply backpressure. Internally it instantiates four `SBox` byte-substitution instances to implement SubWord, and generates one 32-bit schedule word per clock.

## Interface
Parameters: none (AES-128 only; Nk=4, Nr=10 fixed).

Ports:
- `clk` in 1 — sole clock; all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — request expansion of `key`; sampled only in IDLE.
- `key` in 128 — cipher key, sampled on accepted `start`; `key[127:96]` = w0, MSB byte first.
- `rk` out 128 — current round key `{w(4r), w(4r+1), w(4r+2), w(4r+3)}`.
- `rk_round` out 4 — round index of `rk`, 0..10.
- `rk_valid` out 1 — `rk`/`rk_round` valid.
- `rk_ready` in 1 — consumer accepts; handshake = `rk_valid & rk_ready`.
- `busy` out 1 — high from the cycle after an accepted `start` until return to IDLE.
- `done` out 1 — one-cycle pulse after round 10 is handshaken.

## Operation
- State: window registers W0..W3 (32 b each), `rcon` (8 b), round counter (4 b), word index (2 b), FSM.
- FSM states:
  - IDLE: `start=1` latches W0..W3 ← `key`, `rcon` ← 8'h01, round ← 0, goes to PRESENT.
  - PRESENT: `rk_valid=1`. On handshake: if round==10, go to IDLE and assert `done` next cycle. Otherwise go to EXPAND with index ← 0.
  - EXPAND: 4 cycles, one new word per cycle.
    - new = W0 ^ t, where t = SubWord(RotWord(W3)) ^ {rcon, 24'h0} when index==0, else t = W3.
    - Shift the window: W0←W1, W1←W2, W2←W3, W3←new.
    - On index==0, `rcon` ← xtime(rcon): shift left 1; if bit 7 was set, XOR 8'h1b. Sequence: 01,02,04,08,10,20,40,80,1b,36.
    - After index==3: round ← round+1, go to PRESENT.
- RotWord: {b1,b2,b3,b0} of W3 = {b0,b1,b2,b3}. SubWord applies `SBox` to each byte independently.
- `rk` = {W0,W1,W2,W3} continuously. It is only meaningful while `rk_valid`.
- While `rk_valid & !rk_ready`: `rk`, `rk_round`, and `rk_valid` hold stable.
- `start` while not IDLE is ignored (no restart, no key resample).
- `key` changes after acceptance have no effect.
- All arithmetic is GF(2) XOR; no carries. The round counter never exceeds 10.

## Timing
- Reset (any state, including mid-EXPAND or mid-stall):
  - Next cycle: IDLE, `rk`=0, `rk_round`=0, `rk_valid`=0, `busy`=0, `done`=0, `rcon`=8'h01.
  - A pending handshake in the reset cycle is discarded.
- `start` accepted at cycle T → `rk_valid=1`, `rk_round=0`, `rk=key` at T+1; `busy=1` from T+1.
- Handshake at cycle H (round<10) → `rk_valid=0` at H+1..H+4 (EXPAND); next round key valid at H+5.
- With `rk_ready` tied high: round r is valid at T+1+5r; round 10 is valid at T+51; `done`=1 and `busy`=0 at T+52.
- `start` asserted in the same cycle as `done`: accepted (FSM is in IDLE); round 0 valid next cycle.
- SBox path is combinational within the EXPAND index-0 cycle. No extra pipeline stage.

## Test plan
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, ready high → round 0 = key; round 1 = `a0fafe1788542cb123a339392a6c7605`; round 2 = `f2c295f27a96b9435935807a7359f67f`; round 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6` at T+51; `done` at T+52.
- All-zero key → round 1 = `62636363626363636263636362636363`; round 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- Backpressure: drop `rk_ready` for 7 cycles at rounds 3 and 9 → `rk`/`rk_round` stable throughout; final round 10 value unchanged from the ready-high run.
- `start` pulsed with a different key at rounds 0, 5, and 10 while busy → ignored; outputs match the original key's schedule.
- Assert `rst` during EXPAND of round 6 → next cycle all outputs 0 and IDLE. A new `start` with the FIPS key reproduces the correct full schedule (`rcon` restarted at 01).
- Back-to-back runs: `start` asserted in the `done` cycle with the all-zero key → round 0 = 0 at the next cycle; full schedule correct.
